// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame width and bit-time helper
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  // Clock cycles per line bit; transmitter and receiver must agree on this.
  function automatic int calc_bit_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte handshake and status bundle
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] o_data;
  logic                      o_data_valid;
  logic                      i_data_ready;
  logic                      o_frame_err;
  logic                      o_overrun;
  logic                      o_busy;

  modport master (
    output o_data, o_data_valid, o_frame_err, o_overrun, o_busy,
    input  i_data_ready
  );

  modport slave (
    input  o_data, o_data_valid, o_frame_err, o_overrun, o_busy,
    output i_data_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an idle-high asynchronous input
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and one-entry holding register
module uart_receiver #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_rx,
  uart_receiver_if.master rx_if
);
  import uart_pkg::*;

  localparam int          BIT_TIME  = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int          HALF_BIT  = BIT_TIME / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      r_rx_prev;
  uart_state_e               r_state;
  uart_state_e               w_state_next;
  logic [15:0]               r_clk_cnt;
  logic [15:0]               w_clk_cnt_next;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      w_stop_sample;

  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_data_valid;
  logic                      r_frame_err;
  logic                      r_overrun;
  logic                      w_handshake;
  logic                      w_stop_ok;
  logic                      w_stop_bad;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_prev <= 1'b1;
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_prev <= w_rx_s;
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + 16'd1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_stop_sample  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = '0;
        // Edge-triggered so a held-low line (break) cannot start frames.
        if (r_rx_prev && !w_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_next          = '0;
          w_shift_next[r_bit_idx] = w_rx_s;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_next = '0;
          w_stop_sample  = 1'b1;
          w_state_next   = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_handshake = r_data_valid & rx_if.i_data_ready;
  assign w_stop_ok   = w_stop_sample & w_rx_s;
  assign w_stop_bad  = w_stop_sample & ~w_rx_s;

  // A same-cycle handshake frees the slot, so the new byte replaces the old one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_ok & r_data_valid & ~rx_if.i_data_ready;
      if (w_stop_ok && (!r_data_valid || w_handshake)) begin
        r_data       <= r_shift;
        r_data_valid <= 1'b1;
      end else if (w_handshake) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign rx_if.o_data       = r_data;
  assign rx_if.o_data_valid = r_data_valid;
  assign rx_if.o_frame_err  = r_frame_err;
  assign rx_if.o_overrun    = r_overrun;
  assign rx_if.o_busy       = (r_state != ST_IDLE);

endmodule
